// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the writeback / register-file slice.
//   DATA_W    register/data width
//   NREGS     architectural register count (index NREGS-1 is XZR)
//   XZR_IDX   zero register index
//   LINK_REG  branch-and-link destination (X30)
//   reg_idx_t 5-bit register index
//   wb_src_e  writeback value source
package cpu_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned NREGS  = 32;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t XZR_IDX  = 5'd31;
  localparam reg_idx_t LINK_REG = 5'd30;

  typedef enum logic [1:0] {
    WB_SRC_ALU  = 2'd0,
    WB_SRC_MEM  = 2'd1,
    WB_SRC_LINK = 2'd2
  } wb_src_e;

  // BL overrides both the Mem2Reg choice and the instruction's Rd.
  function automatic wb_src_e wb_src_sel(input logic bl, input logic mem2reg);
    if (bl)           return WB_SRC_LINK;
    else if (mem2reg) return WB_SRC_MEM;
    else              return WB_SRC_ALU;
  endfunction

endpackage

// File: rtl/regfile_core.sv
// regfile_core: architectural register storage.
//   clk, reset        clock / async active-high reset (clears all writable regs)
//   we, waddr, wdata  single write port, committed on posedge clk
//   raddr1, raddr2    asynchronous read addresses
//   rdata1, rdata2    read data; the top index (XZR) always reads zero
// Only NREGS-1 entries are stored; the zero register has no storage.
module regfile_core
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned NREGS  = cpu_pkg::NREGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  reg_idx_t          waddr,
  input  logic [DATA_W-1:0] wdata,
  input  reg_idx_t          raddr1,
  input  reg_idx_t          raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam reg_idx_t ZR = reg_idx_t'(NREGS - 1);

  logic [DATA_W-1:0] regs [NREGS-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS - 1; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != ZR)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != ZR) rdata1 = regs[raddr1];
    if (raddr2 != ZR) rdata2 = regs[raddr2];
  end

endmodule

// File: rtl/wb_regfile_stage.sv
// wb_regfile_stage: writeback end of MEM/WB plus the architectural register file.
//   clk, reset                 clock / async active-high reset
//   MEMWB_RegWrite             writeback requested
//   MEMWB_Mem2Reg              1: load data, 0: ALU result
//   MEMWB_BL                   branch-and-link: PC+4 -> X30
//   MEMWB_Rd                   destination register
//   MEMWB_datamem_read_data    load data
//   MEMWB_ALU_out              ALU result
//   MEMWB_PC_p4                link address
//   Ra, Rb                     decode-stage read addresses
//   ReadData1, ReadData2       read data with same-cycle write-through bypass
//   wb_en, wb_rd, wb_data      effective writeback this cycle (to forwarding unit)
//   wb_count                   committed writes since reset (wraps)
module wb_regfile_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned NREGS  = cpu_pkg::NREGS,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MEMWB_RegWrite,
  input  logic              MEMWB_Mem2Reg,
  input  logic              MEMWB_BL,
  input  reg_idx_t          MEMWB_Rd,
  input  logic [DATA_W-1:0] MEMWB_datamem_read_data,
  input  logic [DATA_W-1:0] MEMWB_ALU_out,
  input  logic [DATA_W-1:0] MEMWB_PC_p4,
  input  reg_idx_t          Ra,
  input  reg_idx_t          Rb,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              wb_en,
  output reg_idx_t          wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  wb_count
);

  localparam reg_idx_t ZR = reg_idx_t'(NREGS - 1);

  wb_src_e           wb_src;
  logic [DATA_W-1:0] core_rd1;
  logic [DATA_W-1:0] core_rd2;

  always_comb begin
    wb_src  = wb_src_sel(MEMWB_BL, MEMWB_Mem2Reg);
    wb_data = MEMWB_ALU_out;
    case (wb_src)
      WB_SRC_LINK: wb_data = MEMWB_PC_p4;
      WB_SRC_MEM:  wb_data = MEMWB_datamem_read_data;
      default:     wb_data = MEMWB_ALU_out;
    endcase
    wb_rd = MEMWB_BL ? LINK_REG : MEMWB_Rd;
    wb_en = (MEMWB_RegWrite | MEMWB_BL) & (wb_rd != ZR);
  end

  regfile_core #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_en),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (Ra),
    .raddr2 (Rb),
    .rdata1 (core_rd1),
    .rdata2 (core_rd2)
  );

  // XZR wins over the bypass, so a discarded write to X31 never leaks out.
  always_comb begin
    ReadData1 = core_rd1;
    ReadData2 = core_rd2;
    if (Ra == ZR)                   ReadData1 = '0;
    else if (wb_en && (Ra == wb_rd)) ReadData1 = wb_data;
    if (Rb == ZR)                   ReadData2 = '0;
    else if (wb_en && (Rb == wb_rd)) ReadData2 = wb_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_count <= '0;
    end else if (wb_en) begin
      wb_count <= wb_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_regfile_stage.sv
module tb_wb_regfile_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        RegWrite = 1'b0, Mem2Reg = 1'b0, BL = 1'b0;
  logic [4:0]  Rd = '0, Ra = '0, Rb = '0;
  logic [63:0] rdata = '0, alu = '0, pc = '0;

  logic [63:0] rd1, rd2, wbd;
  logic        wbe;
  logic [4:0]  wbr;
  logic [31:0] cnt;

  logic [63:0] rd1_4, rd2_4, wbd_4;
  logic        wbe_4;
  logic [4:0]  wbr_4;
  logic [3:0]  cnt_4;

  always #5 clk = ~clk;

  wb_regfile_stage #(.DATA_W(64), .NREGS(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .MEMWB_RegWrite(RegWrite), .MEMWB_Mem2Reg(Mem2Reg), .MEMWB_BL(BL), .MEMWB_Rd(Rd),
    .MEMWB_datamem_read_data(rdata), .MEMWB_ALU_out(alu), .MEMWB_PC_p4(pc),
    .Ra(Ra), .Rb(Rb), .ReadData1(rd1), .ReadData2(rd2),
    .wb_en(wbe), .wb_rd(wbr), .wb_data(wbd), .wb_count(cnt)
  );

  wb_regfile_stage #(.DATA_W(64), .NREGS(32), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .MEMWB_RegWrite(RegWrite), .MEMWB_Mem2Reg(Mem2Reg), .MEMWB_BL(BL), .MEMWB_Rd(Rd),
    .MEMWB_datamem_read_data(rdata), .MEMWB_ALU_out(alu), .MEMWB_PC_p4(pc),
    .Ra(Ra), .Rb(Rb), .ReadData1(rd1_4), .ReadData2(rd2_4),
    .wb_en(wbe_4), .wb_rd(wbr_4), .wb_data(wbd_4), .wb_count(cnt_4)
  );

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mregs [32];
  int unsigned mcount;
  logic [3:0]  mcount4;
  logic        e_en;
  logic [4:0]  e_rd;
  logic [63:0] e_data;
  int          checks = 0;
  int          errors = 0;

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mcount  = 0;
    mcount4 = '0;
  endtask

  function automatic logic [63:0] exp_read(input logic [4:0] a);
    if (a == 5'd31) return '0;
    if (e_en && (a == e_rd)) return e_data;
    return mregs[a];
  endfunction

  task automatic push(input string t, input logic [63:0] v);
    exp_t e;
    e.tag = t;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h expected <entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic eval_comb();
    e_rd   = BL ? 5'd30 : Rd;
    e_data = BL ? pc : (Mem2Reg ? rdata : alu);
    e_en   = (RegWrite | BL) && (e_rd != 5'd31);
    push("ReadData1", exp_read(Ra));
    push("ReadData2", exp_read(Rb));
    push("wb_en", {63'd0, e_en});
    push("wb_rd", {59'd0, e_rd});
    push("wb_data", e_data);
    push("ReadData1_c4", exp_read(Ra));
    push("ReadData2_c4", exp_read(Rb));
    push("wb_en_c4", {63'd0, e_en});
    #1;
    check(rd1);
    check(rd2);
    check({63'd0, wbe});
    check({59'd0, wbr});
    check(wbd);
    check(rd1_4);
    check(rd2_4);
    check({63'd0, wbe_4});
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset && e_en) begin
      mregs[e_rd] = e_data;
      mcount++;
      mcount4 = mcount4 + 4'd1;
    end
    push("wb_count", 64'(mcount));
    push("wb_count_c4", 64'(mcount4));
    #1;
    check(64'(cnt));
    check(64'(cnt_4));
  endtask

  task automatic step(input logic rw, input logic m2r, input logic bl, input logic [4:0] rd,
                      input logic [63:0] rdv, input logic [63:0] aluv, input logic [63:0] pcv,
                      input logic [4:0] ra, input logic [4:0] rb);
    RegWrite = rw; Mem2Reg = m2r; BL = bl; Rd = rd;
    rdata = rdv; alu = aluv; pc = pcv; Ra = ra; Rb = rb;
    eval_comb();
    tick();
  endtask

  task automatic bubble(input logic [4:0] ra, input logic [4:0] rb);
    step(1'b0, 1'b0, 1'b0, 5'd0, '0, '0, '0, ra, rb);
  endtask

  initial begin
    clear_model();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // 1: write presented during reset is dropped
    step(1'b1, 1'b0, 1'b0, 5'd5, '0, 64'hAAAA, '0, 5'd0, 5'd0);
    bubble(5'd5, 5'd5);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) bubble(5'(i), 5'(i + 16));

    // 2: ALU writeback with same-cycle bypass, then plain read
    step(1'b1, 1'b0, 1'b0, 5'd3, '0, 64'h1234, '0, 5'd3, 5'd0);
    bubble(5'd3, 5'd3);

    // 3: load writeback, then BL overriding Rd
    step(1'b1, 1'b1, 1'b0, 5'd7, 64'hDEAD_BEEF, 64'h1, '0, 5'd7, 5'd3);
    step(1'b0, 1'b0, 1'b1, 5'd7, 64'h5, 64'h6, 64'h40, 5'd30, 5'd7);
    bubble(5'd30, 5'd7);

    // 4: write to XZR discarded
    step(1'b1, 1'b0, 1'b0, 5'd31, '0, 64'hFFFF, '0, 5'd31, 5'd31);
    bubble(5'd31, 5'd3);

    // 5: back-to-back writes to X9
    step(1'b1, 1'b0, 1'b0, 5'd9, '0, 64'd1, '0, 5'd9, 5'd9);
    step(1'b1, 1'b0, 1'b0, 5'd9, '0, 64'd2, '0, 5'd9, 5'd9);
    bubble(5'd9, 5'd9);

    // Asynchronous reset mid-cycle, with a write pending
    step(1'b1, 1'b0, 1'b0, 5'd12, '0, 64'h55, '0, 5'd12, 5'd3);
    RegWrite = 1'b1; Mem2Reg = 1'b0; BL = 1'b0; Rd = 5'd13;
    alu = 64'h77; Ra = 5'd12; Rb = 5'd13;
    eval_comb();
    #2;
    reset = 1'b1;
    clear_model();
    push("ReadData1_async_rst", '0);
    push("wb_count_async_rst", '0);
    #1;
    check(rd1);
    check(64'(cnt));
    tick();
    reset = 1'b0;
    bubble(5'd13, 5'd12);
    bubble(5'd3, 5'd9);

    // 6: 4-bit counter wraps from all-ones to zero
    for (int i = 0; i < 20 && mcount4 != 4'hF; i++)
      step(1'b1, 1'b0, 1'b0, 5'd1, '0, 64'(i), '0, 5'd1, 5'd2);
    push("wb_count_c4_full", 64'hF);
    check(64'(cnt_4));
    step(1'b1, 1'b0, 1'b0, 5'd2, '0, 64'hABC, '0, 5'd2, 5'd1);
    push("wb_count_c4_wrap", '0);
    check(64'(cnt_4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
